// File: rtl/aes_sequencer.sv
// aes_sequencer: collects a 128-bit key and data block byte by byte,
// shifts them serially into a bit-serial AES core, waits for completion
// (with a timeout), captures the serial result and streams it out as
// 16 bytes with a last marker.
module aes_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    // command
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_decrypt,
    // key/data byte stream in
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_key,
    input  logic [7:0] in_data,
    // result byte stream out
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    // serial AES core drive
    output logic       aes_key_bit,
    output logic       aes_data_bit,
    output logic       aes_start,
    output logic       aes_decrypt,
    // serial AES core result/status
    input  logic       aes_data_out_bit,
    input  logic       aes_busy,
    input  logic       aes_done,
    // status
    output logic       seq_busy,
    output logic       seq_error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_SHIFT   = 3'd2;
    localparam logic [2:0] S_START   = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_CAPTURE = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;
    localparam logic [2:0] S_ERROR   = 3'd7;

    // Wait counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_W = CNT_W'(TIMEOUT_CYCLES);

    logic [2:0]       state_q,    state_d;
    logic             decrypt_q,  decrypt_d;
    logic [127:0]     key_q,      key_d;
    logic [127:0]     data_q,     data_d;
    logic [127:0]     result_q,   result_d;
    logic [6:0]       bit_cnt_q,  bit_cnt_d;
    logic [3:0]       byte_cnt_q, byte_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic idle_like;

    // Output decode: everything is a function of state except cmd_ready,
    // which must also respect the core's busy flag.
    assign idle_like    = (state_q == S_IDLE) || (state_q == S_ERROR);
    assign cmd_ready    = idle_like && !aes_busy;
    assign in_ready     = (state_q == S_COLLECT);
    assign seq_busy     = !idle_like;
    assign seq_error    = (state_q == S_ERROR);
    assign aes_key_bit  = (state_q == S_SHIFT) && key_q[127];
    assign aes_data_bit = (state_q == S_SHIFT) && data_q[127];
    assign aes_start    = (state_q == S_START);
    assign aes_decrypt  = seq_busy && decrypt_q;
    assign out_valid    = (state_q == S_DRAIN);
    assign out_data     = out_valid ? result_q[127:120] : 8'h00;
    assign out_last     = out_valid && (byte_cnt_q == 4'd15);

    // Next-state and datapath logic. Key, data and result live in shift
    // registers: byte 0 / bit 0 of every phase ends up at (or leaves from)
    // the MSB end, so no indexed access is needed.
    always_comb begin
        state_d    = state_q;
        decrypt_d  = decrypt_q;
        key_d      = key_q;
        data_d     = data_q;
        result_d   = result_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        wait_cnt_d = wait_cnt_q;

        case (state_q)
            S_IDLE, S_ERROR: begin
                if (cmd_valid && cmd_ready) begin
                    decrypt_d  = cmd_decrypt;
                    byte_cnt_d = 4'd0;
                    state_d    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (in_valid && in_ready) begin
                    key_d  = {key_q[119:0], in_key};
                    data_d = {data_q[119:0], in_data};
                    if (byte_cnt_q == 4'd15) begin
                        byte_cnt_d = 4'd0;
                        bit_cnt_d  = 7'd0;
                        state_d    = S_SHIFT;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            S_SHIFT: begin
                key_d  = {key_q[126:0], 1'b0};
                data_d = {data_q[126:0], 1'b0};
                if (bit_cnt_q == 7'd127) begin
                    bit_cnt_d  = 7'd0;
                    wait_cnt_d = '0;
                    state_d    = S_START;
                end else begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
            S_START: begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // done wins over an expiring timeout in the same cycle
                if (aes_done) begin
                    bit_cnt_d = 7'd0;
                    state_d   = S_CAPTURE;
                end else if (wait_cnt_q >= TIMEOUT_W) begin
                    state_d = S_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                result_d = {result_q[126:0], aes_data_out_bit};
                if (bit_cnt_q == 7'd127) begin
                    bit_cnt_d  = 7'd0;
                    byte_cnt_d = 4'd0;
                    state_d    = S_DRAIN;
                end else begin
                    bit_cnt_d = bit_cnt_q + 7'd1;
                end
            end
            S_DRAIN: begin
                if (out_ready) begin
                    result_d = {result_q[119:0], 8'h00};
                    if (byte_cnt_q == 4'd15) begin
                        byte_cnt_d = 4'd0;
                        state_d    = S_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            decrypt_q  <= 1'b0;
            key_q      <= '0;
            data_q     <= '0;
            result_q   <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            decrypt_q  <= decrypt_d;
            key_q      <= key_d;
            data_q     <= data_d;
            result_q   <= result_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_aes_sequencer.sv
// Testbench for aes_sequencer: a behavioural bit-serial AES core stand-in
// plus randomized command/byte traffic checked against expected blocks.
module tb_aes_sequencer;

    localparam int TO = 16;
    localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_decrypt = 1'b0;
    logic       in_valid = 1'b0, in_ready;
    logic [7:0] in_key = 8'h00, in_data = 8'h00;
    logic       out_valid, out_ready = 1'b0, out_last;
    logic [7:0] out_data;
    logic       aes_key_bit, aes_data_bit, aes_start, aes_decrypt;
    logic       aes_data_out_bit, aes_busy, aes_done;
    logic       seq_busy, seq_error;

    always #5 clk = ~clk;

    aes_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .aes_key_bit(aes_key_bit), .aes_data_bit(aes_data_bit),
        .aes_start(aes_start), .aes_decrypt(aes_decrypt),
        .aes_data_out_bit(aes_data_out_bit), .aes_busy(aes_busy), .aes_done(aes_done),
        .seq_busy(seq_busy), .seq_error(seq_error)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in for the AES core: known test vectors, otherwise an
    // arbitrary reversible-looking mix so random blocks still check routing.
    function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] d,
                                             input logic dec);
        if (k == K0 && !dec && d == P0) return C0;
        if (k == K0 && dec && d == C0) return P0;
        if (dec) return ~(d ^ k);
        return {d[119:0], d[127:120]} ^ k;
    endfunction

    // ---------------- behavioural core model ----------------
    logic [127:0] hist_key = '0, hist_data = '0;
    logic [127:0] cap_key = '0, cap_data = '0, mock_res = '0;
    int   start_count = 0;
    int   done_delay  = 10;
    bit   hang        = 1'b0;
    int   mock_phase  = 0;
    int   mock_t      = 0;
    logic mock_done = 1'b0, mock_busy = 1'b0, mock_bit = 1'b0;
    logic spur_done = 1'b0, force_busy = 1'b0;

    assign aes_done         = mock_done | spur_done;
    assign aes_busy         = mock_busy | force_busy;
    assign aes_data_out_bit = mock_bit;

    // Acts 1 time unit after each rising edge on this cycle's DUT outputs.
    always begin
        @(posedge clk);
        #1;
        mock_done = 1'b0;
        mock_bit  = 1'b0;
        if (!rst_n) begin
            mock_phase = 0;
            mock_busy  = 1'b0;
        end else begin
            if (aes_start) begin
                start_count++;
                cap_key    = hist_key;
                cap_data   = hist_data;
                mock_res   = core_fn(hist_key, hist_data, aes_decrypt);
                mock_t     = 0;
                mock_phase = 1;
                mock_busy  = !hang;
            end else begin
                case (mock_phase)
                    1: begin
                        mock_t++;
                        if (!hang && mock_t == done_delay) begin
                            mock_done  = 1'b1;
                            mock_phase = 2;
                            mock_t     = 0;
                        end
                    end
                    2: begin
                        mock_bit = mock_res[127 - mock_t];
                        mock_t++;
                        if (mock_t == 128) mock_phase = 3;
                    end
                    3: begin
                        mock_busy  = 1'b0;
                        mock_phase = 0;
                    end
                    default: ;
                endcase
            end
            hist_key  = {hist_key[126:0], aes_key_bit};
            hist_data = {hist_data[126:0], aes_data_bit};
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One complete command; abort_at >= 0 resets the DUT at that SHIFT bit.
    task automatic run_block(input string nm, input logic [127:0] key, input logic [127:0] data,
                             input logic dec, input int bp, input int delay,
                             input bit hang_mode, input int abort_at);
        logic [127:0] exp_res, seen_key, seen_data;
        logic [7:0]   held;
        bit           stalled, early_start, dec_bad;
        int           guard, b, n, s0;
        exp_res   = core_fn(key, data, dec);
        done_delay = delay;
        hang      = hang_mode;
        s0        = start_count;
        dec_bad   = 1'b0;

        cmd_valid   = 1'b1;
        cmd_decrypt = dec;
        guard = 0;
        while (!cmd_ready && guard < 50) begin step(); guard++; end
        check_eq({nm, ".cmd_ready"}, cmd_ready, 1'b1);
        step();
        cmd_valid   = 1'b0;
        cmd_decrypt = 1'($urandom);
        check_eq({nm, ".collect_busy"}, seq_busy, 1'b1);
        check_eq({nm, ".err_cleared"}, seq_error, 1'b0);

        b = 0; guard = 0;
        while (b < 16 && guard < 200) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_key    = key[127 - 8*b -: 8];
            in_data   = data[127 - 8*b -: 8];
            spur_done = 1'($urandom);
            if (aes_decrypt !== dec) dec_bad = 1'b1;
            if (in_valid && in_ready) b++;
            step();
            guard++;
        end
        in_valid  = 1'b0;
        spur_done = 1'b0;
        check_eq({nm, ".beats"}, b, 16);
        check_eq({nm, ".in_ready_shift"}, in_ready, 1'b0);

        if (abort_at >= 0) begin
            repeat (abort_at) step();
            rst_n = 1'b0;
            #1;
            check_eq({nm, ".rst_outs"},
                     {in_ready, out_valid, out_last, out_data, aes_key_bit, aes_data_bit,
                      aes_start, aes_decrypt, seq_busy, seq_error}, '0);
            check_eq({nm, ".rst_cmd_ready"}, cmd_ready, 1'b1);
            step();
            rst_n = 1'b1;
            repeat (5) begin
                step();
                check_eq({nm, ".post_rst_quiet"}, {out_valid, seq_busy, aes_start}, '0);
            end
            return;
        end

        early_start = 1'b0;
        seen_key = '0; seen_data = '0;
        for (int k = 0; k < 128; k++) begin
            seen_key[127 - k]  = aes_key_bit;
            seen_data[127 - k] = aes_data_bit;
            if (aes_start) early_start = 1'b1;
            if (aes_decrypt !== dec) dec_bad = 1'b1;
            step();
        end
        check_eq({nm, ".shift_key"}, seen_key, key);
        check_eq({nm, ".shift_data"}, seen_data, data);
        check_eq({nm, ".no_early_start"}, early_start, 1'b0);
        check_eq({nm, ".start"}, {aes_start, aes_key_bit, aes_data_bit}, 3'b100);

        if (hang_mode) begin
            repeat (TO) step();
            check_eq({nm, ".no_err_at_limit"}, seq_error, 1'b0);
            step();
            check_eq({nm, ".timeout_err"}, {seq_error, seq_busy, cmd_ready}, 3'b101);
            check_eq({nm, ".err_quiet"},
                     {out_valid, aes_start, aes_key_bit, aes_data_bit, aes_decrypt}, '0);
            return;
        end

        n = 0; guard = 0; stalled = 1'b0; held = 8'h00;
        while (n < 16 && guard < 2000) begin
            case (bp)
                0:       out_ready = 1'b1;
                1:       out_ready = guard[0];
                default: out_ready = 1'($urandom);
            endcase
            if (seq_busy && aes_decrypt !== dec) dec_bad = 1'b1;
            if (out_valid) begin
                spur_done = 1'($urandom);
                if (stalled) check_eq($sformatf("%s.hold%0d", nm, n), out_data, held);
                check_eq($sformatf("%s.byte%0d", nm, n), out_data, exp_res[127 - 8*n -: 8]);
                check_eq($sformatf("%s.last%0d", nm, n), out_last, (n == 15));
                if (out_ready) begin
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end else begin
                spur_done = 1'b0;
            end
            step();
            guard++;
        end
        out_ready = 1'b0;
        spur_done = 1'b0;
        check_eq({nm, ".handshakes"}, n, 16);
        check_eq({nm, ".idle_after"}, {out_valid, seq_busy, seq_error}, 3'b000);
        check_eq({nm, ".aes_decrypt"}, dec_bad, 1'b0);
        check_eq({nm, ".one_start"}, start_count - s0, 1);
        check_eq({nm, ".core_key"}, cap_key, key);
        check_eq({nm, ".core_data"}, cap_data, data);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rk, rd;
        #3;
        rst_n      = 1'b0;
        force_busy = 1'b1;
        #1;
        check_eq("reset.cmd_ready_busy", cmd_ready, 1'b0);
        force_busy = 1'b0;
        #1;
        check_eq("reset.cmd_ready_free", cmd_ready, 1'b1);
        check_eq("reset.outs",
                 {in_ready, out_valid, out_last, out_data, aes_key_bit, aes_data_bit,
                  aes_start, aes_decrypt, seq_busy, seq_error}, '0);
        step();
        step();
        rst_n = 1'b1;
        step();

        run_block("enc_kat", K0, P0, 1'b0, 0, 10, 1'b0, -1);
        run_block("dec_kat_bp", K0, C0, 1'b1, 1, 10, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            rd = {$urandom, $urandom, $urandom, $urandom};
            run_block($sformatf("rand%0d", i), rk, rd, 1'($urandom),
                      $urandom_range(0, 2), $urandom_range(1, TO), 1'b0, -1);
        end
        run_block("timeout", K0, P0, 1'b0, 0, 10, 1'b1, -1);
        run_block("after_err", K0, P0, 1'b0, 2, 10, 1'b0, -1);
        run_block("done_at_limit", K0, P0, 1'b0, 0, TO, 1'b0, -1);
        run_block("abort_shift", {128{1'b1}}, {128{1'b1}}, 1'b1, 0, 10, 1'b0, 60);
        run_block("after_abort", K0, P0, 1'b0, 0, 10, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
